// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg
//   Shared definitions for the Risky pipeline sequencing block: the default
//   address width, the controller FSM state size and the state encodings.
package pipeline_controller_pkg;

    // Default fetch address width (the `ADDRESS_SIZE of the architecture).
    localparam int ADDRESS_SIZE    = 32;
    localparam int CTRL_STATE_SIZE = 2;

    typedef enum logic [CTRL_STATE_SIZE-1:0] {
        CTRL_IDLE      = 2'd0,
        CTRL_RUN       = 2'd1,
        CTRL_STEP_WAIT = 2'd2,
        CTRL_HALTED    = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset, count -> 0
//   clear  : synchronous clear, wins over enable
//   enable : count up by one this cycle (ignored once saturated)
//   count  : current value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !(&count_q)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller
//   Sequences the Risky pipeline: arbitrates branch redirects, load-use
//   hazards, execute busy, decoded HALT and run/single-step debug control,
//   and keeps saturating RUN-cycle and stall-cycle counters.
//   Inputs : clock, reset (async, active high), start, step_mode, step,
//            halt_decoded, hazard, busy, branch_taken, branch_target
//   Outputs: halt, stall, jump, jump_pc, flush (combinational, same cycle),
//            state (registered FSM state), cycle_count, stall_count
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int ADDR_W = ADDRESS_SIZE,
    parameter int CNT_W  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       step_mode,
    input  logic                       step,
    input  logic                       halt_decoded,
    input  logic                       hazard,
    input  logic                       busy,
    input  logic                       branch_taken,
    input  logic [ADDR_W-1:0]          branch_target,
    output logic                       halt,
    output logic                       stall,
    output logic                       jump,
    output logic [ADDR_W-1:0]          jump_pc,
    output logic                       flush,
    output logic [CTRL_STATE_SIZE-1:0] state,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [CNT_W-1:0]           stall_count
);

    ctrl_state_e state_q;
    logic        advance;   // RUN cycle in which the pipeline moves forward

    // Control outputs are decoded from the current state and this cycle's
    // inputs so fetch can react at the very next edge.
    always_comb begin
        halt    = 1'b0;
        stall   = 1'b0;
        jump    = 1'b0;
        jump_pc = '0;
        flush   = 1'b0;
        advance = 1'b0;
        if (state_q == CTRL_RUN) begin
            if (busy) begin
                stall = 1'b1;
            end else if (branch_taken) begin
                // hazard / HALT in decode are on the wrong path: drop them
                jump    = 1'b1;
                jump_pc = branch_target;
                flush   = 1'b1;
                advance = 1'b1;
            end else if (halt_decoded) begin
                halt = 1'b1;
            end else if (hazard) begin
                stall = 1'b1;
            end else begin
                advance = 1'b1;
            end
        end else begin
            halt = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CTRL_IDLE;
        end else begin
            case (state_q)
                CTRL_IDLE, CTRL_HALTED: begin
                    if (start) state_q <= CTRL_RUN;
                end
                CTRL_RUN: begin
                    // stalled cycles stay in RUN so a stepped instruction
                    // completes before the next STEP_WAIT
                    if (halt)                      state_q <= CTRL_HALTED;
                    else if (advance && step_mode) state_q <= CTRL_STEP_WAIT;
                end
                CTRL_STEP_WAIT: begin
                    if (!step_mode || step) state_q <= CTRL_RUN;
                end
                default: state_q <= CTRL_IDLE;
            endcase
        end
    end

    assign state = state_q;

    // Leaving IDLE starts a fresh measurement; resuming from HALTED keeps it.
    logic cnt_clear;
    assign cnt_clear = (state_q == CTRL_IDLE) && start;

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (state_q == CTRL_RUN),
        .count  (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable ((state_q == CTRL_RUN) && stall),
        .count  (stall_count)
    );

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central sequencing block for the Risky pipeline. It drives the fetch unit's `halt`, `stall`, `jump` and `jump_pc` inputs and the `flush` kill signal for the decode stage. It arbitrates between branch redirects, load-use hazards, multi-cycle execute busy, decoded HALT instructions and an external run/single-step debug interface. It also keeps saturating cycle and stall performance counters.

## Interface
Parameters:
- `ADDR_W`, default `` `ADDRESS_SIZE ``: width of `branch_target` and `jump_pc`.
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; leaves IDLE or HALTED and enters RUN.
- `step_mode`  in  1  level; 1 = single-step execution.
- `step`  in  1  one-cycle pulse; releases one advance cycle while in STEP_WAIT.
- `halt_decoded`  in  1  decode stage holds a HALT instruction.
- `hazard`  in  1  load-use hazard detected; fetch/decode must hold.
- `busy`  in  1  execute stage is in a multi-cycle operation.
- `branch_taken`  in  1  execute stage resolved a taken branch or jump.
- `branch_target`  in  ADDR_W  redirect address, valid with `branch_taken`.
- `halt`  out  1  freeze fetch (PC and instruction register hold).
- `stall`  out  1  pipeline bubble request (fetch holds, decode inserts NOP).
- `jump`  out  1  redirect fetch to `jump_pc`.
- `jump_pc`  out  ADDR_W  redirect address.
- `flush`  out  1  kill the instruction currently in decode.
- `state`  out  2  current FSM state, for debug.
- `cycle_count`  out  CNT_W  number of cycles spent in RUN.
- `stall_count`  out  CNT_W  number of RUN cycles with `stall`=1.

## Operation
- States: IDLE=0, RUN=1, STEP_WAIT=2, HALTED=3.
- **IDLE:** `halt`=1. A `start` pulse clears both counters and moves to RUN.
- **HALTED:** `halt`=1. A `start` pulse moves to RUN; counters are kept.
- **RUN:** events are resolved in strict priority order, evaluated combinationally in the same cycle.
  1. `busy`=1: `stall`=1. `branch_taken`, `halt_decoded` and `hazard` are ignored.
  2. `branch_taken`=1: `jump`=1, `jump_pc`=`branch_target`, `flush`=1. `hazard` and `halt_decoded` are discarded, because they belong to the wrong path.
  3. `halt_decoded`=1: `halt`=1, and the next state is HALTED.
  4. `hazard`=1: `stall`=1.
  5. Otherwise: an advance cycle, with all control outputs 0.
- **Step mode:** in RUN with `step_mode`=1, every cycle that does not assert `stall` or `halt` moves the FSM to STEP_WAIT. A jump cycle counts as an advance cycle.
- **STEP_WAIT:** `halt`=1. A `step` pulse returns to RUN for exactly one evaluation of the priority list above. If `step_mode` is 0 while in STEP_WAIT, go to RUN.
- **Default outputs:** `jump`, `jump_pc` (0), `flush` and `stall` are 0 outside RUN.
- **Counters:**
  - `cycle_count` increments on every cycle where the state is RUN.
  - `stall_count` increments on every RUN cycle with `stall`=1.
  - Both saturate at all-ones; they never wrap.
- **Reset (any time, including mid-stall or mid-jump):** state=IDLE, `halt`=1, all other outputs 0, counters 0.

## Timing
- The FSM state and counters are registered. `halt`, `stall`, `jump`, `jump_pc` and `flush` are combinational from the state and the current-cycle inputs, with zero latency. This lets the fetch unit act on them at the same edge.
- A `start` sampled in cycle n gives state=RUN in n+1, where `halt` drops (unless HALT is decoded in n+1).
- A `halt_decoded` in RUN cycle n gives `halt`=1 in n and state=HALTED from n+1.
- A `step` in STEP_WAIT cycle n gives RUN in n+1. After that single cycle the FSM returns to STEP_WAIT in n+2, or stays in RUN while that cycle stalls.
- `start` during RUN/STEP_WAIT and `step` outside STEP_WAIT are ignored.

## Structure
- Add to `architecture.vh`:
  - state encodings `CTRL_IDLE`, `CTRL_RUN`, `CTRL_STEP_WAIT`, `CTRL_HALTED`;
  - `CTRL_STATE_SIZE` = 2.
- Sub-module `sat_counter` (parameter `WIDTH`; ports: clock, reset, clear, enable, count), instantiated twice.

## Test plan
- **Reset then start:** hold `reset` high, release, pulse `start` at cycle 3 → state=1 at cycle 4, `halt`=0, `cycle_count`=1 at cycle 5.
- **Branch/hazard/halt coincidence:** in RUN, `branch_taken`=1, `branch_target`=0x2A, with `hazard`=1 and `halt_decoded`=1 → `jump`=1, `jump_pc`=0x2A, `flush`=1, `stall`=0, state stays RUN.
- **Busy masks branch:** `busy`=1 for 3 cycles with `branch_taken`=1 → `stall`=1 and `jump`=0 for 3 cycles, `stall_count`+=3; `busy`=0 in the next cycle → `jump`=1.
- **Halt and resume:** `halt_decoded` in RUN → `halt`=1 the same cycle, state=3 the next. `start` → RUN with `cycle_count` preserved.
- **Single step:** `step_mode`=1 → after one advance cycle state=2, `halt`=1. Each `step` pulse yields exactly one cycle with `halt`=0. A `hazard` during the stepped cycle keeps RUN until it clears.
- **Counter saturation and async reset:** `CNT_W`=4, run 20 cycles → `cycle_count`=15. Assert `reset` mid-cycle → all outputs reset immediately, without waiting for a clock edge.
